// File: rtl/vga_text_ctrl_if.sv
// Bus bundle between vga_text_ctrl, the CPU write path, the command source,
// the VGA timing generator and the character RAM.
interface vga_text_ctrl_if;
  logic        cpu_wr_req;
  logic [11:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ack;
  logic        cpu_wr_err;
  logic        cmd_req;
  logic        cmd_op;
  logic        cmd_ack;
  logic        busy;
  logic        done;
  logic        disp_valid;
  logic [11:0] disp_addr;
  logic [11:0] ram_rdaddr;
  logic [7:0]  ram_q;
  logic [11:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;

  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, cmd_req, cmd_op,
    input  disp_valid, disp_addr, ram_q,
    output cpu_wr_ack, cpu_wr_err, cmd_ack, busy, done,
    output ram_rdaddr, ram_wraddr, ram_data, ram_wren
  );

  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data, cmd_req, cmd_op,
    output disp_valid, disp_addr, ram_q,
    input  cpu_wr_ack, cpu_wr_err, cmd_ack, busy, done,
    input  ram_rdaddr, ram_wraddr, ram_data, ram_wren
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// Write-port arbiter and clear/scroll sequencer for the 70x30 text-mode character RAM.
// Define VGA_TEXT_CTRL_SCROLL_EN to build the scroll engine; otherwise scroll completes as a no-op.
module vga_text_ctrl #(
  parameter int unsigned COLS      = 70,
  parameter int unsigned ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input logic            vga_clk,
  input logic            rst,
  vga_text_ctrl_if.slave bus
);

  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
`ifdef VGA_TEXT_CTRL_SCROLL_EN
  localparam logic [11:0] COLS_W   = 12'(COLS);
  // Last destination that is copied from the row below; the bottom row is filled instead.
  localparam logic [11:0] LAST_SRC = 12'((ROWS - 1) * COLS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_WR   = 3'd1,
    CLR      = 3'd2,
`ifdef VGA_TEXT_CTRL_SCROLL_EN
    SCR_RD   = 3'd3,
    SCR_WAIT = 3'd4,
    SCR_WR   = 3'd5,
    SCR_FILL = 3'd6
`else
    SCR_NOP  = 3'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wren_q, wren_d;
  logic [11:0] wraddr_q, wraddr_d;
  logic [7:0]  data_q, data_d;
`ifdef VGA_TEXT_CTRL_SCROLL_EN
  logic [7:0]  cap_q, cap_d;
`endif

  // State and registered outputs; reset aborts any engine run on the spot.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 12'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cmd_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wren_q    <= 1'b0;
      wraddr_q  <= 12'd0;
      data_q    <= 8'd0;
`ifdef VGA_TEXT_CTRL_SCROLL_EN
      cap_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      cmd_ack_q <= cmd_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wren_q    <= wren_d;
      wraddr_q  <= wraddr_d;
      data_q    <= data_d;
`ifdef VGA_TEXT_CTRL_SCROLL_EN
      cap_q     <= cap_d;
`endif
    end
  end

  // Next-state and next-output logic; CPU writes win over commands in IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    cmd_ack_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wren_d    = 1'b0;
    wraddr_d  = wraddr_q;
    data_d    = data_q;
`ifdef VGA_TEXT_CTRL_SCROLL_EN
    cap_d     = cap_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_wr_req) begin
          state_d = CPU_WR;
          ack_d   = 1'b1;
          if (bus.cpu_wr_addr > LAST_CELL) begin
            err_d = 1'b1;
          end else begin
            wren_d   = 1'b1;
            wraddr_d = bus.cpu_wr_addr;
            data_d   = bus.cpu_wr_data;
          end
        end else if (bus.cmd_req) begin
          cmd_ack_d = 1'b1;
          busy_d    = 1'b1;
          idx_d     = 12'd0;
          if (bus.cmd_op) begin
`ifdef VGA_TEXT_CTRL_SCROLL_EN
            state_d = SCR_RD;
`else
            state_d = SCR_NOP;
`endif
          end else begin
            state_d = CLR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CPU_WR: begin
        state_d = IDLE;
      end
      CLR: begin
        wren_d   = 1'b1;
        wraddr_d = idx_q;
        data_d   = FILL_CHAR;
        idx_d    = idx_q + 12'd1;
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = CLR;
        end
      end
`ifdef VGA_TEXT_CTRL_SCROLL_EN
      SCR_RD: begin
        if (bus.disp_valid) begin
          state_d = SCR_RD;
        end else begin
          state_d = SCR_WAIT;
        end
      end
      SCR_WAIT: begin
        cap_d   = bus.ram_q;
        state_d = SCR_WR;
      end
      SCR_WR: begin
        wren_d   = 1'b1;
        wraddr_d = idx_q;
        data_d   = cap_q;
        idx_d    = idx_q + 12'd1;
        if (idx_q == LAST_SRC) begin
          state_d = SCR_FILL;
        end else begin
          state_d = SCR_RD;
        end
      end
      SCR_FILL: begin
        wren_d   = 1'b1;
        wraddr_d = idx_q;
        data_d   = FILL_CHAR;
        idx_d    = idx_q + 12'd1;
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = SCR_FILL;
        end
      end
`else
      SCR_NOP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.cpu_wr_ack = ack_q;
  assign bus.cpu_wr_err = err_q;
  assign bus.cmd_ack    = cmd_ack_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ram_wren   = wren_q;
  assign bus.ram_wraddr = wraddr_q;
  assign bus.ram_data   = data_q;

`ifdef VGA_TEXT_CTRL_SCROLL_EN
  // The read port is borrowed only in a blanking SCR_RD cycle.
  assign bus.ram_rdaddr = (state_q == SCR_RD && !bus.disp_valid) ? (idx_q + COLS_W) : bus.disp_addr;
`else
  logic unused_rd_s;
  assign bus.ram_rdaddr = bus.disp_addr;
  assign unused_rd_s    = ^{bus.disp_valid, bus.ram_q};
`endif

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomized bench for vga_text_ctrl: behavioural RAM plus a whole-screen reference image
// updated from the screen-level rules (write cell, clear screen, shift up one row).
module tb_vga_text_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int DEPTH = 4096;

  logic vga_clk = 1'b0;
  logic rst     = 1'b0;
  logic load    = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   dv_on  = 640;
  int   dv_per = 800;
  int   dv_ph  = 0;

  logic [7:0] mem     [0:DEPTH-1];
  logic [7:0] pre_mem [0:DEPTH-1];
  logic [7:0] exp_mem [0:DEPTH-1];
  logic [7:0] nxt_mem [0:DEPTH-1];

  vga_text_ctrl_if bus ();
  vga_text_ctrl dut (.vga_clk(vga_clk), .rst(rst), .bus(bus));

  always #5 vga_clk = ~vga_clk;

  // Character RAM: one write port, registered read with one cycle of latency.
  always @(posedge vga_clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_mem[i];
    end else if (bus.ram_wren === 1'b1) begin
      mem[bus.ram_wraddr] <= bus.ram_data;
    end
    bus.ram_q <= mem[bus.ram_rdaddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input bit ramp);
    for (int i = 0; i < DEPTH; i++) begin
      pre_mem[i] = ramp ? 8'(i) : 8'($urandom);
      exp_mem[i] = pre_mem[i];
    end
    load = 1'b1;
    @(negedge vga_clk);
    load = 1'b0;
  endtask

  task automatic mem_cmp(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic drive_disp();
    bus.disp_valid = ((dv_ph % dv_per) < dv_on);
    bus.disp_addr  = 12'($urandom);
    dv_ph++;
  endtask

  // Called at a negedge with the controller idle.
  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input bit hold);
    int lat;
    bit in_range;
    lat = 0;
    in_range = (int'(a) < CELLS);
    bus.cpu_wr_addr = a;
    bus.cpu_wr_data = d;
    bus.cpu_wr_req  = 1'b1;
    do begin
      @(negedge vga_clk);
      lat++;
    end while (bus.cpu_wr_ack !== 1'b1 && lat < 50);
    chk("cpu_ack_lat", lat, 1);
    chk("cpu_err", bus.cpu_wr_err, !in_range);
    chk("cpu_wren", bus.ram_wren, in_range);
    if (in_range) begin
      chk("cpu_wraddr", bus.ram_wraddr, a);
      chk("cpu_data", bus.ram_data, d);
      exp_mem[a] = d;
    end
    if (!hold) bus.cpu_wr_req = 1'b0;
    @(negedge vga_clk);
    chk("cpu_no_rewrite", {bus.cpu_wr_ack, bus.ram_wren}, 2'b00);
    bus.cpu_wr_req = 1'b0;
  endtask

  // Runs one engine command; optionally raises a CPU write 500 cycles in.
  task automatic run_cmd(input bit op, input bit mid_cpu);
    int cyc, lat, nexp, nwr, bad_wr, rd_dev, busy_bad, extra_done;
    int done_cyc, last_wr_cyc, first_wr_cyc, ack_cyc;
    bit cpu_pend;
    logic [11:0] ca;
    logic [7:0]  cd;
    for (int i = 0; i < DEPTH; i++) nxt_mem[i] = exp_mem[i];
    nexp = 0;
    if (!op) begin
      for (int i = 0; i < CELLS; i++) nxt_mem[i] = 8'h20;
      nexp = CELLS;
    end else begin
`ifdef VGA_TEXT_CTRL_SCROLL_EN
      for (int i = 0; i < CELLS; i++) nxt_mem[i] = (i < CELLS - COLS) ? exp_mem[i + COLS] : 8'h20;
      nexp = CELLS;
`endif
    end
    bus.cmd_op  = op;
    bus.cmd_req = 1'b1;
    lat = 0;
    do begin
      @(negedge vga_clk);
      lat++;
    end while (bus.cmd_ack !== 1'b1 && lat < 50);
    chk("cmd_ack_lat", lat, 1);
    chk("busy_on_ack", bus.busy, 1'b1);
    bus.cmd_req = 1'b0;
    cyc = 0; nwr = 0; bad_wr = 0; rd_dev = 0; busy_bad = 0; extra_done = 0;
    done_cyc = -1; last_wr_cyc = -1; first_wr_cyc = -1; ack_cyc = -1;
    cpu_pend = 1'b0;
    ca = 12'($urandom_range(0, CELLS - 1));
    cd = 8'($urandom);
    while ((done_cyc < 0 || cpu_pend) && cyc < 60000) begin
      drive_disp();
      if (mid_cpu && cyc == 500) begin
        bus.cpu_wr_addr = ca;
        bus.cpu_wr_data = cd;
        bus.cpu_wr_req  = 1'b1;
        cpu_pend        = 1'b1;
      end
      @(negedge vga_clk);
      cyc++;
      if ((bus.disp_valid || !op) && bus.ram_rdaddr !== bus.disp_addr) rd_dev++;
      if (bus.cpu_wr_ack === 1'b1) begin
        ack_cyc = cyc;
        cpu_pend = 1'b0;
        bus.cpu_wr_req = 1'b0;
        chk("mid_cpu_write", {bus.ram_wren, bus.ram_wraddr, bus.ram_data}, {1'b1, ca, cd});
      end else if (bus.ram_wren === 1'b1) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (nwr >= nexp || bus.ram_wraddr !== 12'(nwr) || bus.ram_data !== nxt_mem[nwr]) bad_wr++;
        nwr++;
        last_wr_cyc = cyc;
      end
      if (bus.done === 1'b1) begin
        if (done_cyc >= 0) extra_done++;
        else done_cyc = cyc;
      end
      if (done_cyc < 0 && bus.busy !== 1'b1) busy_bad++;
      if (done_cyc == cyc && bus.busy !== 1'b0) busy_bad++;
    end
    chk("eng_done_seen", done_cyc >= 0, 1'b1);
    chk("eng_nwr", nwr, nexp);
    chk("eng_wr_bad", bad_wr, 0);
    chk("eng_done_on_last", done_cyc, (nexp > 0) ? last_wr_cyc : 1);
    chk("eng_busy", busy_bad, 0);
    chk("eng_extra_done", extra_done, 0);
    chk("eng_rd_dev", rd_dev, 0);
    if (!op) chk("clr_first_wr", first_wr_cyc, 1);
    if (mid_cpu) chk("mid_cpu_after_done", ack_cyc, done_cyc + 1);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = nxt_mem[i];
    if (mid_cpu) exp_mem[ca] = cd;
    @(negedge vga_clk);
    mem_cmp(op ? "scroll_mem" : "clear_mem");
  endtask

  initial begin
    int cyc, cpu_ack_cyc, cmd_ack_cyc, nd;
    bit hit, dn;
    logic [11:0] a;
    logic [7:0]  d;
    bus.cpu_wr_req = 1'b0; bus.cpu_wr_addr = 12'd0; bus.cpu_wr_data = 8'd0;
    bus.cmd_req = 1'b0; bus.cmd_op = 1'b0;
    bus.disp_valid = 1'b0; bus.disp_addr = 12'd0;
    #1 rst = 1'b1;
    preload(1'b0);
    repeat (2) @(negedge vga_clk);
    chk("reset_outs", {bus.cpu_wr_ack, bus.cpu_wr_err, bus.cmd_ack, bus.busy, bus.done,
                       bus.ram_wren, bus.ram_wraddr, bus.ram_data}, 32'd0);
    rst = 1'b0;
    @(negedge vga_clk);

    cpu_write(12'd5, 8'h41, 1'b1);
    cpu_write(12'd2100, 8'h55, 1'b0);
    cpu_write(12'd2099, 8'h7e, 1'b0);
    for (int k = 0; k < 30; k++) begin
      a = 12'($urandom_range(0, 2199));
      d = 8'($urandom);
      cpu_write(a, d, 1'($urandom));
    end
    @(negedge vga_clk);
    mem_cmp("cpu_rand_mem");

    run_cmd(1'b0, 1'b1);

    preload(1'b1);
    dv_on = 640; dv_per = 800; dv_ph = 0;
    run_cmd(1'b1, 1'b0);

    preload(1'b0);
    dv_on = 200; dv_ph = $urandom_range(0, 799);
    run_cmd(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      a = 12'($urandom_range(0, CELLS - 1));
      cpu_write(a, 8'($urandom), 1'b0);
    end
    @(negedge vga_clk);
    mem_cmp("post_scroll_cpu_mem");

    // CPU write and clear requested together.
    a = 12'($urandom_range(0, CELLS - 1));
    d = 8'($urandom);
    bus.cpu_wr_addr = a; bus.cpu_wr_data = d; bus.cpu_wr_req = 1'b1;
    bus.cmd_op = 1'b0; bus.cmd_req = 1'b1;
    cyc = 0; cpu_ack_cyc = -1; cmd_ack_cyc = -1; dn = 1'b0;
    while (!dn && cyc < 3000) begin
      @(negedge vga_clk);
      cyc++;
      if (bus.cpu_wr_ack === 1'b1) begin cpu_ack_cyc = cyc; bus.cpu_wr_req = 1'b0; end
      if (bus.cmd_ack === 1'b1) begin cmd_ack_cyc = cyc; bus.cmd_req = 1'b0; end
      if (bus.done === 1'b1) dn = 1'b1;
    end
    chk("simul_cpu_ack", cpu_ack_cyc, 1);
    chk("simul_cmd_ack", cmd_ack_cyc, 3);
    chk("simul_done", dn, 1'b1);
    exp_mem[a] = d;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h20;
    @(negedge vga_clk);
    mem_cmp("simul_mem");

    // Reset in the middle of a clear.
    preload(1'b0);
    bus.cmd_op = 1'b0; bus.cmd_req = 1'b1;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 3000) begin
      @(negedge vga_clk);
      cyc++;
      if (bus.cmd_ack === 1'b1) bus.cmd_req = 1'b0;
      if (bus.ram_wren === 1'b1 && bus.ram_wraddr == 12'd1000) hit = 1'b1;
    end
    bus.cmd_req = 1'b0;
    chk("rst_reach_1000", hit, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {bus.cpu_wr_ack, bus.cpu_wr_err, bus.cmd_ack, bus.busy, bus.done,
                         bus.ram_wren, bus.ram_wraddr, bus.ram_data}, 32'd0);
    for (int i = 0; i < 1000; i++) exp_mem[i] = 8'h20;
    repeat (3) @(negedge vga_clk);
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge vga_clk);
      if (bus.done !== 1'b0 || bus.ram_wren !== 1'b0 || bus.busy !== 1'b0) nd++;
    end
    chk("rst_no_resume", nd, 0);
    mem_cmp("rst_mem");
    cpu_write(12'($urandom_range(0, CELLS - 1)), 8'($urandom), 1'b0);
    @(negedge vga_clk);
    mem_cmp("rst_after_cpu_mem");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
